// File: rtl/tpu_pkg.sv
// Shared types for the TPU command path: the 64-bit tile command and the sequencer state.
package tpu_pkg;

    localparam int unsigned CMD_WIDTH  = 64;
    localparam int unsigned CMD_ADDR_W = 10;
    localparam int unsigned CMD_DIM_W  = 8;

    localparam int unsigned CMD_M_LSB = 0;
    localparam int unsigned CMD_K_LSB = 8;
    localparam int unsigned CMD_N_LSB = 16;
    localparam int unsigned CMD_A_LSB = 24;
    localparam int unsigned CMD_B_LSB = 34;
    localparam int unsigned CMD_C_LSB = 44;
    localparam int unsigned CMD_D_LSB = 54;

    typedef struct packed {
        logic [CMD_ADDR_W-1:0] d;
        logic [CMD_ADDR_W-1:0] c;
        logic [CMD_ADDR_W-1:0] b;
        logic [CMD_ADDR_W-1:0] a;
        logic [CMD_DIM_W-1:0]  n;
        logic [CMD_DIM_W-1:0]  k;
        logic [CMD_DIM_W-1:0]  m;
    } cmd_t;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_SETUP,
        SEQ_ISSUE,
        SEQ_DRAIN
    } seq_state_e;

endpackage

// File: rtl/tile_index_counter.sv
// Nested k/i/j tile walker (j fastest, k slowest) with per-tile edge lengths.
module tile_index_counter #(
    parameter int unsigned SYSTOLIC_ARRAY_WIDTH = 16,
    parameter int unsigned DIM_WIDTH            = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 advance,
    input  logic [DIM_WIDTH-1:0] dim_m,
    input  logic [DIM_WIDTH-1:0] dim_k,
    input  logic [DIM_WIDTH-1:0] dim_n,
    input  logic [DIM_WIDTH-1:0] mt,
    input  logic [DIM_WIDTH-1:0] kt,
    input  logic [DIM_WIDTH-1:0] nt,
    output logic [DIM_WIDTH-1:0] k_idx,
    output logic [DIM_WIDTH-1:0] i_idx,
    output logic [DIM_WIDTH-1:0] j_idx,
    output logic [DIM_WIDTH-1:0] m_edge,
    output logic [DIM_WIDTH-1:0] k_edge,
    output logic [DIM_WIDTH-1:0] n_edge,
    output logic                 first,
    output logic                 last
);

    localparam int unsigned W  = SYSTOLIC_ARRAY_WIDTH;
    localparam int unsigned EW = 2 * DIM_WIDTH;

    logic j_wrap, i_wrap, k_wrap;

    // Remaining extent past the tile origin, clipped to one tile edge.
    function automatic logic [DIM_WIDTH-1:0] tile_len(input logic [DIM_WIDTH-1:0] dim,
                                                      input logic [DIM_WIDTH-1:0] idx);
        logic [EW-1:0] rem;
        rem = EW'(dim) - EW'(idx) * EW'(W);
        return (rem > EW'(W)) ? DIM_WIDTH'(W) : DIM_WIDTH'(rem);
    endfunction

    assign j_wrap = (j_idx == nt - DIM_WIDTH'(1));
    assign i_wrap = (i_idx == mt - DIM_WIDTH'(1));
    assign k_wrap = (k_idx == kt - DIM_WIDTH'(1));

    assign m_edge = tile_len(dim_m, i_idx);
    assign k_edge = tile_len(dim_k, k_idx);
    assign n_edge = tile_len(dim_n, j_idx);

    // first marks the first K pass (no accumulation dependency)
    assign first = (k_idx == '0);
    assign last  = j_wrap && i_wrap && k_wrap;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            k_idx <= '0;
            i_idx <= '0;
            j_idx <= '0;
        end else if (advance) begin
            if (j_wrap) begin
                j_idx <= '0;
                if (i_wrap) begin
                    i_idx <= '0;
                    k_idx <= k_idx + DIM_WIDTH'(1);
                end else begin
                    i_idx <= i_idx + DIM_WIDTH'(1);
                end
            end else begin
                j_idx <= j_idx + DIM_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/gemm_tile_sequencer.sv
// Splits one GEMM job into WxW tile commands for control_unit, gating K-accumulation
// tiles on completion of their predecessor and bounding commands in flight.
module gemm_tile_sequencer
    import tpu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH           = 10,
    parameter int unsigned SYSTOLIC_ARRAY_WIDTH = 16,
    parameter int unsigned DIM_WIDTH            = 8,
    parameter int unsigned MAX_OUTSTANDING      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [ADDR_WIDTH-1:0] job_a_base,
    input  logic [ADDR_WIDTH-1:0] job_b_base,
    input  logic [ADDR_WIDTH-1:0] job_c_base,
    input  logic [ADDR_WIDTH-1:0] job_d_base,
    input  logic [DIM_WIDTH-1:0]  job_m,
    input  logic [DIM_WIDTH-1:0]  job_k,
    input  logic [DIM_WIDTH-1:0]  job_n,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [63:0]           cmd_data,
    input  logic                  done_irq,
    output logic                  busy,
    output logic                  job_done,
    output logic                  job_err
);

    localparam int unsigned W     = SYSTOLIC_ARRAY_WIDTH;
    localparam int unsigned AW    = ADDR_WIDTH;
    localparam int unsigned EW    = 2 * DIM_WIDTH;
    localparam int unsigned PW    = 3 * DIM_WIDTH;
    localparam int unsigned CNT_W = 13;
    localparam int unsigned CW1   = CNT_W + 1;

    seq_state_e state;

    logic [AW-1:0]        a_base, b_base, c_base, d_base;
    logic [DIM_WIDTH-1:0] dim_m, dim_k, dim_n, mt, kt, nt;
    logic [CNT_W-1:0]     total, plane, issued, completed;
    logic                 all_loaded;

    logic [DIM_WIDTH-1:0] k_idx, i_idx, j_idx, m_edge, k_edge, n_edge;
    logic                 first, last;

    logic                 job_zero, hs, load, dep_ok, room_ok;
    logic [DIM_WIDTH-1:0] mt_in, kt_in, nt_in;
    logic [CNT_W-1:0]     issued_nx, completed_nx;
    logic [AW-1:0]        a_addr, b_addr, c_addr, d_addr, tile_off;
    cmd_t                 cand;

    function automatic logic [DIM_WIDTH-1:0] ceil_tiles(input logic [DIM_WIDTH-1:0] d);
        return DIM_WIDTH'((EW'(d) + EW'(W - 1)) / EW'(W));
    endfunction

    tile_index_counter #(
        .SYSTOLIC_ARRAY_WIDTH(W),
        .DIM_WIDTH           (DIM_WIDTH)
    ) u_idx (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == SEQ_IDLE),
        .advance(load),
        .dim_m  (dim_m),
        .dim_k  (dim_k),
        .dim_n  (dim_n),
        .mt     (mt),
        .kt     (kt),
        .nt     (nt),
        .k_idx  (k_idx),
        .i_idx  (i_idx),
        .j_idx  (j_idx),
        .m_edge (m_edge),
        .k_edge (k_edge),
        .n_edge (n_edge),
        .first  (first),
        .last   (last)
    );

    // Gate and candidate command; gates see this cycle's handshake and completion.
    always_comb begin
        job_zero     = (job_m == '0) || (job_k == '0) || (job_n == '0);
        mt_in        = ceil_tiles(job_m);
        kt_in        = ceil_tiles(job_k);
        nt_in        = ceil_tiles(job_n);
        hs           = cmd_valid && cmd_ready;
        issued_nx    = issued + CNT_W'(hs);
        completed_nx = completed + CNT_W'(done_irq && (state != SEQ_IDLE));
        dep_ok       = first || (CW1'(completed_nx) + CW1'(plane) > CW1'(issued_nx));
        room_ok      = (issued_nx - completed_nx) < CNT_W'(MAX_OUTSTANDING);
        load         = ((state == SEQ_SETUP) || (state == SEQ_ISSUE)) && !all_loaded &&
                       (!cmd_valid || hs) && dep_ok && room_ok;

        tile_off = (AW'(i_idx) * AW'(nt) + AW'(j_idx)) * AW'(W);
        a_addr   = a_base + (AW'(i_idx) * AW'(kt) + AW'(k_idx)) * AW'(W);
        b_addr   = b_base + (AW'(k_idx) * AW'(nt) + AW'(j_idx)) * AW'(W);
        d_addr   = d_base + tile_off;
        c_addr   = first ? (c_base + tile_off) : d_addr;

        cand = '{d: CMD_ADDR_W'(d_addr), c: CMD_ADDR_W'(c_addr),
                 b: CMD_ADDR_W'(b_addr), a: CMD_ADDR_W'(a_addr),
                 n: CMD_DIM_W'(n_edge), k: CMD_DIM_W'(k_edge), m: CMD_DIM_W'(m_edge)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SEQ_IDLE;
            job_ready  <= 1'b1;
            busy       <= 1'b0;
            job_done   <= 1'b0;
            job_err    <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd_data   <= '0;
            issued     <= '0;
            completed  <= '0;
            all_loaded <= 1'b0;
            a_base     <= '0;
            b_base     <= '0;
            c_base     <= '0;
            d_base     <= '0;
            dim_m      <= '0;
            dim_k      <= '0;
            dim_n      <= '0;
            mt         <= '0;
            kt         <= '0;
            nt         <= '0;
            total      <= '0;
            plane      <= '0;
        end else begin
            job_done  <= 1'b0;
            job_err   <= 1'b0;
            issued    <= issued_nx;
            completed <= completed_nx;

            // Once presented, a command is held until accepted
            if (load) begin
                cmd_valid <= 1'b1;
                cmd_data  <= cand;
                if (last) all_loaded <= 1'b1;
            end else if (hs) begin
                cmd_valid <= 1'b0;
            end

            case (state)
                SEQ_IDLE: begin
                    if (job_valid) begin
                        if (job_zero) begin
                            job_err <= 1'b1;
                        end else begin
                            state      <= SEQ_SETUP;
                            busy       <= 1'b1;
                            job_ready  <= 1'b0;
                            issued     <= '0;
                            completed  <= '0;
                            all_loaded <= 1'b0;
                            a_base     <= job_a_base;
                            b_base     <= job_b_base;
                            c_base     <= job_c_base;
                            d_base     <= job_d_base;
                            dim_m      <= job_m;
                            dim_k      <= job_k;
                            dim_n      <= job_n;
                            mt         <= mt_in;
                            kt         <= kt_in;
                            nt         <= nt_in;
                            total      <= CNT_W'(PW'(mt_in) * PW'(kt_in) * PW'(nt_in));
                            plane      <= CNT_W'(EW'(mt_in) * EW'(nt_in));
                        end
                    end
                end
                SEQ_SETUP: state <= SEQ_ISSUE;
                SEQ_ISSUE: if (hs && all_loaded) state <= SEQ_DRAIN;
                SEQ_DRAIN: begin
                    // Stay one extra cycle so busy covers the job_done pulse
                    if (job_done) begin
                        state     <= SEQ_IDLE;
                        busy      <= 1'b0;
                        job_ready <= 1'b1;
                    end else if (completed_nx == total) begin
                        job_done <= 1'b1;
                    end
                end
                default: state <= SEQ_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Randomized bench for gemm_tile_sequencer: emulates control_unit and checks every command
// against a tile list computed directly from the job arithmetic.
module tb_gemm_tile_sequencer;

    localparam int W        = 16;
    localparam int MAX_OUT  = 4;
    localparam int ADDR_MOD = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        job_valid;
    logic        job_ready;
    logic [9:0]  job_a_base, job_b_base, job_c_base, job_d_base;
    logic [7:0]  job_m, job_k, job_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [63:0] cmd_data;
    logic        done_irq;
    logic        busy;
    logic        job_done;
    logic        job_err;

    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] got_q[$];

    always #5 clk = ~clk;

    gemm_tile_sequencer #(
        .ADDR_WIDTH          (10),
        .SYSTOLIC_ARRAY_WIDTH(W),
        .DIM_WIDTH           (8),
        .MAX_OUTSTANDING     (MAX_OUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .job_valid (job_valid),
        .job_ready (job_ready),
        .job_a_base(job_a_base),
        .job_b_base(job_b_base),
        .job_c_base(job_c_base),
        .job_d_base(job_d_base),
        .job_m     (job_m),
        .job_k     (job_k),
        .job_n     (job_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .done_irq  (done_irq),
        .busy      (busy),
        .job_done  (job_done),
        .job_err   (job_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int min_w(input int rem);
        return (rem < W) ? rem : W;
    endfunction

    // Runs one job end to end; abort_after > 0 stops after that many handshakes.
    task automatic run_job(input int m, input int k, input int n,
                           input int ab, input int bb, input int cb, input int db,
                           input int stall_at, input int abort_after,
                           input int ready_pct, input int done_pct);
        logic [63:0] exp_q[$];
        logic [63:0] hold_data;
        int mt, kt, nt, tot, plane, idx, cmpl, stall_left, a, b, c, d;
        logic hold, rdy, dn, finished, dep_ok, room_ok;

        mt = (m + W - 1) / W;
        kt = (k + W - 1) / W;
        nt = (n + W - 1) / W;
        tot = mt * kt * nt;
        plane = mt * nt;
        for (int kk = 0; kk < kt; kk++)
            for (int ii = 0; ii < mt; ii++)
                for (int jj = 0; jj < nt; jj++) begin
                    a = (ab + (ii * kt + kk) * W) % ADDR_MOD;
                    b = (bb + (kk * nt + jj) * W) % ADDR_MOD;
                    d = (db + (ii * nt + jj) * W) % ADDR_MOD;
                    c = (kk == 0) ? (cb + (ii * nt + jj) * W) % ADDR_MOD : d;
                    exp_q.push_back({10'(d), 10'(c), 10'(b), 10'(a),
                                     8'(min_w(n - jj * W)), 8'(min_w(k - kk * W)),
                                     8'(min_w(m - ii * W))});
                end
        got_q.delete();

        @(posedge clk); #1;
        check_eq("job_ready_idle", 64'(job_ready), 64'(1));
        job_valid = 1'b1;
        job_m = 8'(m); job_k = 8'(k); job_n = 8'(n);
        job_a_base = 10'(ab); job_b_base = 10'(bb); job_c_base = 10'(cb); job_d_base = 10'(db);
        cmd_ready = 1'b0; done_irq = 1'b0;
        @(posedge clk); #1;
        job_valid = 1'b0;
        check_eq("busy_setup", 64'(busy), 64'(1));
        check_eq("valid_setup", 64'(cmd_valid), 64'(0));

        idx = 0; cmpl = 0; hold = 1'b0; hold_data = '0; stall_left = 5; finished = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 0) check_eq("first_valid_t2", 64'(cmd_valid), 64'(1));
            if (hold) begin
                check_eq("hold_valid", 64'(cmd_valid), 64'(1));
                check_eq("hold_data", cmd_data, hold_data);
            end else if (cmd_valid) begin
                if (idx >= tot) begin
                    check_eq("extra_cmd", 64'(cmd_valid), 64'(0));
                end else begin
                    dep_ok  = (idx < plane) || (cmpl >= idx - plane + 1);
                    room_ok = (idx - cmpl) < MAX_OUT;
                    check_eq("dep_gate", 64'(dep_ok), 64'(1));
                    check_eq("outstanding", 64'(room_ok), 64'(1));
                end
            end
            if (cmpl == tot && idx == tot) begin
                check_eq("job_done", 64'(job_done), 64'(1));
                check_eq("busy_at_done", 64'(busy), 64'(1));
                cmd_ready = 1'b0; done_irq = 1'b0;
                finished = 1'b1;
                break;
            end
            check_eq("busy", 64'(busy), 64'(1));
            check_eq("job_done_early", 64'(job_done), 64'(0));

            if (stall_at >= 0 && idx == stall_at && stall_left > 0 && cmd_valid) begin
                rdy = 1'b0;
                stall_left--;
            end else begin
                rdy = ($urandom_range(0, 99) < ready_pct);
            end
            dn = (idx > cmpl) && ($urandom_range(0, 99) < done_pct);
            cmd_ready = rdy;
            done_irq = dn;
            if (cmd_valid && rdy) begin
                if (idx < tot) check_eq("cmd_data", cmd_data, exp_q[idx]);
                got_q.push_back(cmd_data);
                idx++;
                hold = 1'b0;
            end else begin
                hold = cmd_valid;
                hold_data = cmd_data;
            end
            if (dn) cmpl++;
            if (abort_after > 0 && idx == abort_after) return;
        end

        if (!finished) begin
            check_eq("job_done_timeout", 64'(job_done), 64'(1));
            cmd_ready = 1'b0; done_irq = 1'b0;
        end else begin
            @(posedge clk); #1;
            check_eq("busy_after", 64'(busy), 64'(0));
            check_eq("ready_after", 64'(job_ready), 64'(1));
            check_eq("done_one_cycle", 64'(job_done), 64'(0));
        end
    endtask

    initial begin
        logic [63:0] want;
        rst = 1'b1; job_valid = 1'b0; cmd_ready = 1'b0; done_irq = 1'b0;
        job_a_base = '0; job_b_base = '0; job_c_base = '0; job_d_base = '0;
        job_m = '0; job_k = '0; job_n = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cmd_valid", 64'(cmd_valid), 64'(0));
        check_eq("rst_cmd_data", cmd_data, 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_job_done", 64'(job_done), 64'(0));
        check_eq("rst_job_err", 64'(job_err), 64'(0));
        check_eq("rst_job_ready", 64'(job_ready), 64'(1));
        rst = 1'b0;

        // Single tile
        run_job(16, 16, 16, 0, 100, 200, 300, -1, 0, 100, 50);
        check_eq("single_count", 64'(got_q.size()), 64'(1));
        want = {10'd300, 10'd200, 10'd100, 10'd0, 8'd16, 8'd16, 8'd16};
        if (got_q.size() > 0) check_eq("single_cmd0", got_q[0], want);

        // Ragged M: second row tile is 8 rows
        run_job(24, 16, 16, 0, 100, 200, 300, -1, 0, 100, 50);
        check_eq("m24_count", 64'(got_q.size()), 64'(2));
        want = {10'd316, 10'd216, 10'd100, 10'd16, 8'd16, 8'd16, 8'd8};
        if (got_q.size() > 1) check_eq("m24_cmd1", got_q[1], want);

        // K accumulation: second pass reads C from D
        run_job(16, 32, 16, 0, 100, 200, 300, -1, 0, 100, 25);
        check_eq("k32_count", 64'(got_q.size()), 64'(2));
        want = {10'd300, 10'd300, 10'd116, 10'd16, 8'd16, 8'd16, 8'd16};
        if (got_q.size() > 1) check_eq("k32_cmd1", got_q[1], want);

        // Back-pressure stall for 5 cycles mid-job
        run_job(16, 16, 64, 10, 20, 30, 40, 2, 0, 100, 40);
        check_eq("stall_count", 64'(got_q.size()), 64'(4));

        // Zero dimension rejected
        @(posedge clk); #1;
        job_valid = 1'b1; job_m = 8'd16; job_k = 8'd0; job_n = 8'd16;
        @(posedge clk); #1;
        job_valid = 1'b0;
        check_eq("err_pulse", 64'(job_err), 64'(1));
        check_eq("err_busy", 64'(busy), 64'(0));
        check_eq("err_ready", 64'(job_ready), 64'(1));
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check_eq("err_no_cmd", 64'(cmd_valid), 64'(0));
            check_eq("err_busy_low", 64'(busy), 64'(0));
            check_eq("err_one_cycle", 64'(job_err), 64'(0));
        end

        // Reset mid-job, then restart from tile 0
        run_job(16, 16, 64, 5, 6, 7, 8, -1, 2, 100, 30);
        @(posedge clk); #1;
        rst = 1'b1; cmd_ready = 1'b0; done_irq = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("abort_valid", 64'(cmd_valid), 64'(0));
        check_eq("abort_busy", 64'(busy), 64'(0));
        check_eq("abort_ready", 64'(job_ready), 64'(1));
        run_job(16, 16, 64, 5, 6, 7, 8, -1, 0, 100, 30);
        check_eq("restart_count", 64'(got_q.size()), 64'(4));

        // Boundary shapes: 1-wide edges, address wrap, long dependency chain
        run_job(255, 1, 17, 1020, 1000, 990, 1010, -1, 0, 80, 50);
        run_job(8, 200, 8, 3, 900, 50, 1000, -1, 0, 90, 30);
        run_job(40, 100, 20, 512, 7, 1023, 600, -1, 0, 70, 60);

        for (int r = 0; r < 8; r++)
            run_job(int'($urandom_range(1, 64)), int'($urandom_range(1, 64)),
                    int'($urandom_range(1, 64)),
                    int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                    int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                    -1, 0, 70, 40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gemm_tile_sequencer.md
# gemm_tile_sequencer

- Sits directly upstream of `control_unit` and drives its command port.
- Accepts one whole-GEMM job descriptor, D = A·B + C with M, K, N of up to 255 elements.
- Splits the job into W×W tile commands in `control_unit`'s 64-bit packed format.
- Tracks tile completions via `done_irq`, and withholds any K-accumulation tile until the tile it depends on has been written back.

## Interface
Parameters:
- `ADDR_WIDTH`, 10: SRAM word address width; must be ≤ 10 (command field width).
- `SYSTOLIC_ARRAY_WIDTH`, 16: tile edge W; one tile = W consecutive words.
- `DIM_WIDTH`, 8: job dimension width.
- `MAX_OUTSTANDING`, 4: maximum number of commands issued but not yet completed.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `job_valid` / `job_ready`  in / out  1  job handshake.
- `job_a_base`, `job_b_base`, `job_c_base`, `job_d_base`  in  ADDR_WIDTH each  buffer base addresses.
- `job_m`, `job_k`, `job_n`  in  DIM_WIDTH each  job dimensions.
- `cmd_valid`  out  1  command valid to `control_unit`.
- `cmd_ready`  in  1  `control_unit` can accept a command.
- `cmd_data`  out  64  packed as `{D[63:54], C[53:44], B[43:34], A[33:24], N[23:16], K[15:8], M[7:0]}`.
- `done_irq`  in  1  one pulse per completed command.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `job_done`  out  1  one-cycle pulse when the job is complete.
- `job_err`  out  1  one-cycle pulse when a job is rejected.

## Operation
Tile counts: MT = ceil(M/W), KT = ceil(K/W), NT = ceil(N/W); total commands T = MT·KT·NT (≤ 4096, 13-bit counters).

Issue order:
- k outermost, then i, then j.
- Command index n = k·MT·NT + i·NT + j.

Tile edges: m = min(W, M − i·W), kk = min(W, K − k·W), n_e = min(W, N − j·W).

Addresses (all mod 2^ADDR_WIDTH; wrap is not flagged):
- A = a_base + (i·KT + k)·W
- B = b_base + (k·NT + j)·W
- D = d_base + (i·NT + j)·W
- C = c_base + (i·NT + j)·W when k = 0; C = the D address of the same (i, j) tile when k > 0 (accumulate in place).

Issue gating:
- Dependency: a command with k > 0 depends on command n − MT·NT. It may issue only when completed ≥ n − MT·NT + 1.
- Outstanding limit: a command may issue only when issued − completed < MAX_OUTSTANDING.

Completion counting:
- `done_irq` increments `completed` in any state except IDLE.
- `done_irq` is ignored in IDLE.

FSM states:
- **IDLE**: `job_ready` = 1. A job with any zero dimension pulses `job_err` for one cycle, issues no commands and stays in IDLE. Any other job moves to SETUP.
- **SETUP**: compute MT, KT, NT and T; clear counters; go to ISSUE.
- **ISSUE**: present the current tile; the handshake completes on `cmd_valid && cmd_ready`, then advance to the next tile. When a gating condition fails, drop `cmd_valid` and stay in ISSUE. After the last handshake, go to DRAIN.
- **DRAIN**: wait until completed == T, then pulse `job_done` and return to IDLE.

## Timing
Reset values: `cmd_valid` = 0, `cmd_data` = 0, `busy` = 0, `job_done` = 0, `job_err` = 0, `job_ready` = 1. All counters clear. Reset mid-job aborts the job and leaves no command pending.

Latency:
- Job accepted in cycle t; SETUP in t+1; first `cmd_valid` in t+2.
- `busy` = 1 from t+1 until the cycle `job_done` is asserted, inclusive.

Command handshake:
- `cmd_data` is registered.
- Once asserted, `cmd_valid` and `cmd_data` stay stable until the handshake completes.
- Sustained rate is one command per cycle while `cmd_ready` = 1 and no gate is active.

Simultaneous events:
- `done_irq` in the same cycle as a handshake: both counters update.
- The gate evaluation in cycle t+1 sees both updates.

`job_done` timing: asserted the cycle after the final completion is counted.

## Structure
Shared package `tpu_pkg` holds:
- `cmd_t`: packed struct for the 64-bit command.
- Field-position constants for that struct.
- State enum `seq_state_e`.

One sub-module, `tile_index_counter`, is natural. It provides:
- The nested k/i/j counters.
- Edge-size computation (m, kk, n_e).
- First and last tile flags.

## Test plan
- Job M = K = N = 16, bases A = 0, B = 100, C = 200, D = 300 -> single command with data = {300, 200, 100, 0, 16, 16, 16}; one `done_irq` -> `job_done` pulse, `busy` falls.
- M = 24, K = N = 16 -> two commands:
  - cmd0: M = 16, A = 0, C = 200, D = 300.
  - cmd1: M = 8, A = 16, C = 216, D = 316.
- K = 32, M = N = 16:
  - cmd0 carries A = 0, B = 100, C = 200.
  - cmd1 carries A = 16, B = 116, C = 300, D = 300.
  - cmd1 `cmd_valid` stays low until cmd0's `done_irq`.
- `cmd_ready` held low for 5 cycles mid-job -> `cmd_valid` and `cmd_data` held stable; no command skipped or duplicated.
- `job_k` = 0 -> `job_err` pulse, no `cmd_valid`, `busy` stays 0.
- `rst` asserted after 2 of 4 commands -> next cycle `cmd_valid` = 0, `busy` = 0; a new job restarts from index 0.
